alu_control_unit: RTL and testbench

//  Multi-cycle control sequencer that drives the ALU: accepts an instruction word via valid/ready, decodes it,

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_instr_decoder.sv | 63 ++++++
 rtl/alu_control_unit.sv | 135 +++++++++++++
 tb/tb_alu_control_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: ALU function codes,
// opcodes, FSM state encoding and the decoded-instruction bundle.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_SLL  = 4'h2;
   localparam logic [3:0] ALU_SRL  = 4'h3;
   localparam logic [3:0] ALU_AND  = 4'h8;
   localparam logic [3:0] ALU_OR   = 4'h9;
   localparam logic [3:0] ALU_NOT  = 4'ha;
   localparam logic [3:0] ALU_XOR  = 4'hb;
   localparam logic [3:0] ALU_NAND = 4'hc;
   localparam logic [3:0] ALU_NOR  = 4'hd;
   localparam logic [3:0] ALU_XNOR = 4'he;
   localparam logic [3:0] ALU_EQ   = 4'hf;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h01;
   localparam logic [5:0] OP_LW    = 6'h02;
   localparam logic [5:0] OP_SW    = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_JMP   = 6'h05;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE   = 3'd0,
      CLS_ADDI    = 3'd1,
      CLS_LW      = 3'd2,
      CLS_SW      = 3'd3,
      CLS_BEQ     = 3'd4,
      CLS_JMP     = 3'd5,
      CLS_ILLEGAL = 3'd6
   } instr_class_t;

   typedef struct packed {
      logic [4:0]   rs_addr;
      logic [4:0]   rt_addr;
      logic [4:0]   rd_addr;
      logic [31:0]  imm_ext;
      logic [3:0]   alu_fun;
      logic         alu_src_b;
      instr_class_t cls;
      logic         illegal;
   } decode_t;

endpackage

// File: rtl/alu_instr_decoder.sv
// Purely combinational instruction decode: register fields, extended
// immediate, ALU function, B-operand select, instruction class and legality.
module alu_instr_decoder
   import alu_pkg::*;
#(
   parameter bit IMM_SIGNED = 1'b1
) (
   input  logic [31:0] instr,
   output decode_t     dec
);

   always_comb begin
      dec           = '0;
      dec.rd_addr   = instr[25:21];
      dec.rs_addr   = instr[20:16];
      dec.rt_addr   = instr[15:11];
      dec.imm_ext   = IMM_SIGNED ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};
      dec.alu_fun   = ALU_ADD;
      dec.alu_src_b = 1'b0;
      dec.cls       = CLS_ILLEGAL;
      dec.illegal   = 1'b1;
      case (instr[31:26])
         OP_RTYPE: begin
            // funct 4..7 have no ALU operation behind them
            case (instr[3:0])
               ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_AND, ALU_OR,
               ALU_NOT, ALU_XOR, ALU_NAND, ALU_NOR, ALU_XNOR, ALU_EQ: begin
                  dec.cls     = CLS_RTYPE;
                  dec.illegal = 1'b0;
                  dec.alu_fun = instr[3:0];
               end
               default: ;
            endcase
         end
         OP_ADDI: begin
            dec.cls       = CLS_ADDI;
            dec.illegal   = 1'b0;
            dec.alu_src_b = 1'b1;
         end
         OP_LW: begin
            dec.cls       = CLS_LW;
            dec.illegal   = 1'b0;
            dec.alu_src_b = 1'b1;
         end
         OP_SW: begin
            dec.cls       = CLS_SW;
            dec.illegal   = 1'b0;
            dec.alu_src_b = 1'b1;
         end
         OP_BEQ: begin
            dec.cls     = CLS_BEQ;
            dec.illegal = 1'b0;
            dec.alu_fun = ALU_EQ;
         end
         OP_JMP: begin
            dec.cls     = CLS_JMP;
            dec.illegal = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle control sequencer for the ALU datapath: fetch handshake,
// decode, EXEC/MEM/WB sequencing and single-cycle PC strobes.
module alu_control_unit
   import alu_pkg::*;
#(
   parameter bit IMM_SIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Instr_valid,
   input  logic [31:0] Instr,
   output logic        Instr_ready,
   input  logic        Zero,
   output logic [3:0]  Alu_fun,
   output logic [4:0]  Rs_addr,
   output logic [4:0]  Rt_addr,
   output logic [4:0]  Rd_addr,
   output logic [31:0] Imm_ext,
   output logic        AluSrcB,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        Mem_req,
   output logic        Mem_we,
   input  logic        Mem_ack,
   output logic        Pc_inc,
   output logic        Pc_branch,
   output logic        Pc_jump,
   output logic        Illegal,
   output state_t      dbg_state
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] instr_q;
   logic        run_q;
   logic        illegal_q;
   decode_t     dec;

   alu_instr_decoder #(.IMM_SIGNED(IMM_SIGNED)) u_dec (
      .instr (instr_q),
      .dec   (dec)
   );

   // Handshake: an instruction transfers on a rising edge where Instr_valid
   // and Instr_ready are both 1; Instr_ready never depends on Instr_valid.
   // run_q holds Instr_ready low for the first cycle after reset releases.
   assign Instr_ready = run_q && (state == ST_FETCH);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         instr_q   <= '0;
         run_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         state <= state_nxt;
         if (Instr_ready && Instr_valid)
            instr_q <= Instr;
         if (state == ST_DECODE && dec.illegal)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      RegWrite  = 1'b0;
      MemToReg  = 1'b0;
      Mem_req   = 1'b0;
      Mem_we    = 1'b0;
      Pc_inc    = 1'b0;
      Pc_branch = 1'b0;
      Pc_jump   = 1'b0;
      case (state)
         ST_FETCH: begin
            if (Instr_ready && Instr_valid)
               state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            if (dec.illegal) begin
               Pc_inc    = 1'b1;
               state_nxt = ST_FETCH;
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (dec.cls)
               CLS_RTYPE, CLS_ADDI: state_nxt = ST_WB;
               CLS_LW, CLS_SW:      state_nxt = ST_MEM;
               CLS_BEQ: begin
                  Pc_branch = Zero;
                  Pc_inc    = !Zero;
                  state_nxt = ST_FETCH;
               end
               CLS_JMP: begin
                  Pc_jump   = 1'b1;
                  state_nxt = ST_FETCH;
               end
               default: state_nxt = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            Mem_req = 1'b1;
            Mem_we  = (dec.cls == CLS_SW);
            if (Mem_ack) begin
               // stores retire in the ack cycle; loads still need write-back
               if (dec.cls == CLS_SW) begin
                  Pc_inc    = 1'b1;
                  state_nxt = ST_FETCH;
               end else begin
                  state_nxt = ST_WB;
               end
            end
         end
         ST_WB: begin
            RegWrite  = 1'b1;
            MemToReg  = (dec.cls == CLS_LW);
            Pc_inc    = 1'b1;
            state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

   assign Alu_fun   = dec.alu_fun;
   assign AluSrcB   = dec.alu_src_b;
   assign Rs_addr   = dec.rs_addr;
   assign Rt_addr   = dec.rt_addr;
   assign Rd_addr   = dec.rd_addr;
   assign Imm_ext   = dec.imm_ext;
   assign Illegal   = illegal_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: per-instruction expectations are queued
// at issue time and compared when the PC strobe for that instruction appears.
module tb_alu_control_unit;
   import alu_pkg::*;

   localparam int W = 18;

   logic        clk = 1'b0;
   logic        reset;
   logic        Instr_valid;
   logic [31:0] Instr;
   logic        Instr_ready;
   logic        Zero;
   logic [3:0]  Alu_fun;
   logic [4:0]  Rs_addr, Rt_addr, Rd_addr;
   logic [31:0] Imm_ext;
   logic        AluSrcB, RegWrite, MemToReg, Mem_req, Mem_we, Mem_ack;
   logic        Pc_inc, Pc_branch, Pc_jump, Illegal;
   state_t      dbg_state;

   logic        z_instr_ready;
   logic [3:0]  z_alu_fun;
   logic [4:0]  z_rs, z_rt, z_rd;
   logic [31:0] z_imm_ext;
   logic        z_alu_src_b, z_reg_write, z_mem_to_reg, z_mem_req, z_mem_we;
   logic        z_pc_inc, z_pc_branch, z_pc_jump, z_illegal;
   state_t      z_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   int mreq_m  = 0;
   bit cur_z;
   int cur_n;
   logic [W-1:0] exp_q[$];

   alu_control_unit #(.IMM_SIGNED(1'b1)) dut (
      .clk(clk), .reset(reset), .Instr_valid(Instr_valid), .Instr(Instr),
      .Instr_ready(Instr_ready), .Zero(Zero), .Alu_fun(Alu_fun),
      .Rs_addr(Rs_addr), .Rt_addr(Rt_addr), .Rd_addr(Rd_addr), .Imm_ext(Imm_ext),
      .AluSrcB(AluSrcB), .RegWrite(RegWrite), .MemToReg(MemToReg),
      .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_ack(Mem_ack),
      .Pc_inc(Pc_inc), .Pc_branch(Pc_branch), .Pc_jump(Pc_jump),
      .Illegal(Illegal), .dbg_state(dbg_state)
   );

   alu_control_unit #(.IMM_SIGNED(1'b0)) dut_z (
      .clk(clk), .reset(reset), .Instr_valid(Instr_valid), .Instr(Instr),
      .Instr_ready(z_instr_ready), .Zero(Zero), .Alu_fun(z_alu_fun),
      .Rs_addr(z_rs), .Rt_addr(z_rt), .Rd_addr(z_rd), .Imm_ext(z_imm_ext),
      .AluSrcB(z_alu_src_b), .RegWrite(z_reg_write), .MemToReg(z_mem_to_reg),
      .Mem_req(z_mem_req), .Mem_we(z_mem_we), .Mem_ack(Mem_ack),
      .Pc_inc(z_pc_inc), .Pc_branch(z_pc_branch), .Pc_jump(z_pc_jump),
      .Illegal(z_illegal), .dbg_state(z_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected {inc,branch,jump,regwrite,memtoreg,mem_we,mem_req_cycles,latency}
   function automatic logic [W-1:0] model(logic [31:0] ins, bit z, int n);
      logic inc, br, jp, rw, m2r, we;
      logic [3:0] mq;
      int lat;
      {inc, br, jp, rw, m2r, we} = '0;
      mq  = '0;
      lat = 1;
      case (ins[31:26])
         6'h00, 6'h01: begin
            if (ins[31:26] == 6'h00 && ins[3:0] >= 4'h4 && ins[3:0] <= 4'h7) begin
               inc = 1'b1; lat = 1;
            end else begin
               inc = 1'b1; rw = 1'b1; lat = 3;
            end
         end
         6'h02: begin inc = 1'b1; rw = 1'b1; m2r = 1'b1; mq = 4'(n); lat = n + 3; end
         6'h03: begin inc = 1'b1; we = 1'b1; mq = 4'(n); lat = n + 2; end
         6'h04: begin br = z; inc = !z; lat = 2; end
         6'h05: begin jp = 1'b1; lat = 2; end
         default: begin inc = 1'b1; lat = 1; end
      endcase
      return {inc, br, jp, rw, m2r, we, mq, 8'(lat)};
   endfunction

   // scoreboard: pop one expectation per PC strobe
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic strobe;
      if (!reset) begin
         strobe = Pc_inc | Pc_branch | Pc_jump;
         if (Instr_valid && Instr_ready) begin
            acc_cyc = cyc + 1;
            mreq_m  = 0;
         end
         if (Mem_req) mreq_m++;
         if (RegWrite && !strobe) chk("regwrite_without_pc", 1'b1, 1'b0);
         if (strobe) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", {Pc_inc, Pc_branch, Pc_jump}, 3'b000);
            end else begin
               e = exp_q.pop_front();
               chk("retire", {Pc_inc, Pc_branch, Pc_jump, RegWrite, MemToReg, Mem_we,
                              4'(mreq_m), 8'(cyc - acc_cyc + 1)}, e);
            end
         end
      end
   end

   // driver: called just after a rising edge, returns one cycle after accept (DECODE)
   task automatic send(input logic [31:0] ins, input bit z, input int n, input bit push);
      int g = 0;
      cur_z = z;
      cur_n = n;
      Instr = ins;
      Instr_valid = 1'b1;
      while (!Instr_ready && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      total++;
      assert (Instr_ready) else begin
         bad++;
         $error("FAIL accept_timeout observed=%0b expected=1", Instr_ready);
      end
      if (push) exp_q.push_back(model(ins, z, n));
      @(posedge clk); #1;
      Instr_valid = 1'b0;
      Instr = $urandom();
   endtask

   // memory/flag responder until the instruction's PC strobe has been seen
   task automatic run_to_strobe();
      int mcnt = 0;
      bit done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         Zero = cur_z;
         if (Mem_req) begin
            mcnt++;
            Mem_ack = (mcnt >= cur_n);
         end else begin
            Mem_ack = 1'b0;
         end
         @(negedge clk);
         done = Pc_inc | Pc_branch | Pc_jump;
         @(posedge clk); #1;
         Mem_ack = 1'b0;
         Zero = 1'b0;
      end
      total++;
      assert (done) else begin
         bad++;
         $error("FAIL strobe_timeout observed=0 expected=1");
      end
   endtask

   initial begin
      logic [3:0]  legal_f[12];
      logic [31:0] ins;
      logic [3:0]  f;
      int g;
      legal_f = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf};

      // reset dominates a pending instruction and a stray ack
      reset = 1'b1; Instr_valid = 1'b1; Instr = 32'h0462_1000; Zero = 1'b1; Mem_ack = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", Instr_ready, 1'b0);
      chk("rst_alu_fun", Alu_fun, 4'h0);
      chk("rst_ctrl", {AluSrcB, RegWrite, MemToReg, Mem_req, Mem_we, Pc_inc, Pc_branch, Pc_jump, Illegal}, 9'h0);
      chk("rst_state", dbg_state, ST_FETCH);
      chk("rst_imm", Imm_ext, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; Instr_valid = 1'b0; Zero = 1'b0; Mem_ack = 1'b0;
      @(negedge clk);
      chk("ready_first_cycle", Instr_ready, 1'b0);
      @(posedge clk); #1;
      chk("ready_after_rst", Instr_ready, 1'b1);

      // R-type add rd=3 rs=1 rt=2
      ins = {6'h00, 5'd3, 5'd1, 5'd2, 7'h00, 4'h0};
      send(ins, 1'b0, 0, 1'b1);
      chk("radd_fields", {Rd_addr, Rs_addr, Rt_addr}, {5'd3, 5'd1, 5'd2});
      chk("radd_alu", {Alu_fun, AluSrcB}, {4'h0, 1'b0});
      chk("radd_state", dbg_state, ST_DECODE);
      run_to_strobe();

      // ADDI with all-ones immediate, both extension modes
      ins = {6'h01, 5'd5, 5'd4, 16'hFFFF};
      send(ins, 1'b0, 0, 1'b1);
      chk("addi_imm_sext", Imm_ext, 32'hFFFF_FFFF);
      chk("addi_srcb", {Alu_fun, AluSrcB}, {4'h0, 1'b1});
      chk("addi_imm_zext", z_imm_ext, 32'h0000_FFFF);
      chk("addi_zdut_ctrl", {z_instr_ready, z_alu_fun, z_rs, z_rt, z_rd, z_alu_src_b, z_reg_write,
                             z_mem_to_reg, z_mem_req, z_mem_we, z_pc_inc, z_pc_branch, z_pc_jump,
                             z_illegal, z_state},
                            {1'b0, 4'h0, 5'd4, 5'h1F, 5'd5, 1'b1, 8'h00, ST_DECODE});
      run_to_strobe();

      // random legal R-type functions and register fields
      for (int i = 0; i < 5; i++) begin
         f = legal_f[$urandom_range(0, 11)];
         ins = {6'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)), f};
         send(ins, 1'b0, 0, 1'b1);
         chk("rrand_alu", {Alu_fun, AluSrcB}, {f, 1'b0});
         chk("rrand_fields", {Rd_addr, Rs_addr, Rt_addr}, {ins[25:21], ins[20:16], ins[15:11]});
         run_to_strobe();
      end

      // BEQ taken and not taken
      for (int i = 0; i < 2; i++) begin
         ins = {6'h04, 5'd0, 5'd7, 5'd9, 11'h010};
         send(ins, (i == 0), 0, 1'b1);
         @(posedge clk); #1;
         chk("beq_exec_alu", {Alu_fun, AluSrcB}, {4'hf, 1'b0});
         chk("beq_exec_state", dbg_state, ST_EXEC);
         run_to_strobe();
      end

      // JMP
      send({6'h05, 26'h123_4567}, 1'b0, 0, 1'b1);
      run_to_strobe();

      // loads and stores with 1..3 memory cycles
      send({6'h02, 5'd6, 5'd2, 16'h0040}, 1'b0, 3, 1'b1);
      run_to_strobe();
      send({6'h02, 5'd0, 5'd2, 16'h8004}, 1'b0, 1, 1'b1);
      run_to_strobe();
      send({6'h03, 5'd0, 5'd3, 16'h0008}, 1'b0, 1, 1'b1);
      run_to_strobe();
      send({6'h03, 5'd0, 5'd3, 16'h000C}, 1'b0, 2, 1'b1);
      run_to_strobe();

      // illegal opcode and illegal funct; flag is sticky across a legal op
      chk("illegal_clear", Illegal, 1'b0);
      send(32'hFC00_0000, 1'b0, 0, 1'b1);
      run_to_strobe();
      chk("illegal_set", Illegal, 1'b1);
      send({6'h00, 5'd1, 5'd1, 5'd1, 7'h00, 4'h5}, 1'b0, 0, 1'b1);
      run_to_strobe();
      send({6'h01, 5'd2, 5'd2, 16'h0001}, 1'b0, 0, 1'b1);
      run_to_strobe();
      chk("illegal_sticky", Illegal, 1'b1);

      // reset in the middle of a store's memory phase
      send({6'h03, 5'd0, 5'd4, 16'h0010}, 1'b0, 5, 1'b0);
      g = 0;
      while (!Mem_req && g < 10) begin
         @(posedge clk); #1;
         g++;
      end
      chk("sw_mem_req", {Mem_req, Mem_we}, 2'b11);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_mem_req", {Mem_req, Mem_we}, 2'b00);
      chk("mid_rst_no_retire", {Pc_inc, Pc_branch, Pc_jump, RegWrite, Instr_ready}, 5'h0);
      chk("mid_rst_illegal", Illegal, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready_low", Instr_ready, 1'b0);
      @(posedge clk); #1;
      chk("mid_rst_ready_high", Instr_ready, 1'b1);

      // normal operation after reset
      send({6'h01, 5'd9, 5'd8, 16'h7FFF}, 1'b0, 0, 1'b1);
      chk("post_rst_imm", Imm_ext, 32'h0000_7FFF);
      run_to_strobe();

      repeat (3) @(posedge clk);
      chk("queue_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
